// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - shared CPU widths and the CDB request slot type
package fcpu_pkg;

  localparam int DATA_W    = 32;
  localparam int RSV_ID_W  = 4;
  localparam int CDB_W     = RSV_ID_W + DATA_W;
  localparam int N_CDB_REQ = 4;

  typedef struct packed {
    logic             exception;
    logic [CDB_W-1:0] data;
  } cdb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter searching from ptr with wrap
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 any
);

  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);

  logic [PTR_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk offsets 0..N-1 from ptr; the first occupied index wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx_sum >= N_W) idx_sum = idx_sum - N_W;
      idx = idx_sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with per-unit holding slots; CDB_ARB_FIXED_PRIO_EN selects fixed priority
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = N_CDB_REQ,
  parameter int CDB_W = fcpu_pkg::CDB_W
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0][CDB_W-1:0]  req_data,
  input  logic [N_REQ-1:0]             req_exception,
  input  logic                         rob_clear,
  output logic                         cdb_valid,
  output logic                         cdb_exception,
  output logic [CDB_W-1:0]             cdb
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            hold_valid;
  logic [N_REQ-1:0][CDB_W-1:0] hold_data;
  logic [N_REQ-1:0]            hold_exc;
  logic [N_REQ-1:0]            grant_raw;
  logic [N_REQ-1:0]            grant;
  logic                        any_hold;
  logic                        take;
  logic [PTR_W-1:0]            arb_ptr;
  logic [CDB_W-1:0]            sel_data;
  logic                        sel_exc;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (hold_valid),
    .ptr   (arb_ptr),
    .grant (grant_raw),
    .any   (any_hold)
  );

  // A flush suppresses the grant so nothing pending reaches the bus.
  assign take      = any_hold & ~rob_clear;
  assign grant     = take ? grant_raw : '0;
  assign req_ready = {N_REQ{~nrst & ~rob_clear}} & (~hold_valid | grant);

  always_comb begin
    sel_data = '0;
    sel_exc  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_raw[i]) begin
        sel_data = sel_data | hold_data[i];
        sel_exc  = sel_exc | hold_exc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      hold_valid    <= '0;
      cdb_valid     <= 1'b0;
      cdb_exception <= 1'b0;
      cdb           <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= req_data[i];
          hold_exc[i]   <= req_exception[i];
        end else if (rob_clear || grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      cdb_valid <= take;
      if (take) begin
        cdb           <= sel_data;
        cdb_exception <= sel_exc;
      end
    end
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;

  always_comb begin
    next_ptr = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_raw[i]) next_ptr = (i == N_REQ-1) ? '0 : PTR_W'(i+1);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst)      rr_ptr <= '0;
    else if (take) rr_ptr <= next_ptr;
  end

  assign arb_ptr = rr_ptr;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - vector table, directed sequences and random traffic against a slot-level model
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 4;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    rob_clear;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N-1:0][CDB_W-1:0] req_data;
  logic [N-1:0]            req_exception;
  logic                    cdb_valid;
  logic                    cdb_exception;
  logic [CDB_W-1:0]        cdb;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .CDB_W(CDB_W)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .req_exception (req_exception),
    .rob_clear     (rob_clear),
    .cdb_valid     (cdb_valid),
    .cdb_exception (cdb_exception),
    .cdb           (cdb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  cdb_req_t         m_slot[N];
  bit               m_hv[N];
  int               m_ptr;
  logic             m_cv;
  logic             m_cexc;
  logic [CDB_W-1:0] m_cdb;

  typedef struct {
    logic        rst;
    logic        clr;
    logic [3:0]  v;
    logic [3:0]  exc;
    logic [3:0]  tag;
    logic [31:0] dat;
    logic [3:0]  rdy;
    logic        cv;
    logic        cexc;
    logic [35:0] ocdb;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: model predicts readiness from its slots, then the broadcast after the edge.
  task automatic tick(output logic [N-1:0] rdy);
    int k;
    int u;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    k = -1;
    if (!nrst && !rob_clear) begin
      for (int j = 0; j < N; j++) begin
        u = (m_ptr + j) % N;
        if (k < 0 && m_hv[u]) k = u;
      end
    end
    exp_rdy = '0;
    for (int i = 0; i < N; i++)
      exp_rdy[i] = !nrst && !rob_clear && (!m_hv[i] || k == i);
    rdy = req_ready;
    chk("model_ready", 64'(req_ready), 64'(exp_rdy));
    if (nrst) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_ptr = 0; m_cv = 1'b0; m_cexc = 1'b0; m_cdb = '0;
    end else if (rob_clear) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_cv = 1'b0;
    end else begin
      m_cv = (k >= 0);
      if (k >= 0) begin
        m_cdb   = m_slot[k].data;
        m_cexc  = m_slot[k].exception;
        m_hv[k] = 1'b0;
        m_ptr   = (k + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_rdy[i]) begin
          m_hv[i]   = 1'b1;
          m_slot[i] = '{exception: req_exception[i], data: req_data[i]};
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model_cdb_valid", 64'(cdb_valid), 64'(m_cv));
    chk("model_cdb", 64'(cdb), 64'(m_cdb));
    chk("model_cdb_exception", 64'(cdb_exception), 64'(m_cexc));
  endtask

  // Unit index goes in the low data bits so the winner is identifiable on the bus.
  task automatic set_req(input logic [3:0] v, input logic [3:0] tag);
    req_valid     = v;
    req_exception = '0;
    for (int i = 0; i < N; i++) req_data[i] = {tag, 32'(i)};
  endtask

  initial begin
    logic [N-1:0] r;
    nrst = 1'b1; rob_clear = 1'b0; req_valid = '0; req_exception = '0; req_data = '0;

    tbl[0]  = '{1, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'h0, 0, 0, 36'h0};
    tbl[1]  = '{0, 0, 4'b0100, 4'b0000, 4'h5, 32'hDEADBEEF, 4'hF, 0, 0, 36'h0};
    tbl[2]  = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 1, 0, 36'h5DEADBEEF};
    tbl[3]  = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 0, 0, 36'h5DEADBEEF};
    tbl[4]  = '{0, 0, 4'b0010, 4'b0000, 4'h1, 32'h11,       4'hF, 0, 0, 36'h5DEADBEEF};
    tbl[5]  = '{0, 0, 4'b0010, 4'b0000, 4'h2, 32'h11,       4'hF, 1, 0, 36'h100000011};
    tbl[6]  = '{0, 0, 4'b0010, 4'b0000, 4'h3, 32'h11,       4'hF, 1, 0, 36'h200000011};
    tbl[7]  = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 1, 0, 36'h300000011};
    tbl[8]  = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 0, 0, 36'h300000011};
    tbl[9]  = '{0, 0, 4'b1000, 4'b1000, 4'h9, 32'h99,       4'hF, 0, 0, 36'h300000011};
    tbl[10] = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 1, 1, 36'h900000099};
    tbl[11] = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 0, 1, 36'h900000099};
    tbl[12] = '{0, 0, 4'b1001, 4'b0000, 4'h7, 32'h77,       4'hF, 0, 1, 36'h900000099};
    tbl[13] = '{0, 1, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'h0, 0, 1, 36'h900000099};
    tbl[14] = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 0, 1, 36'h900000099};
    tbl[15] = '{0, 0, 4'b0000, 4'b0000, 4'h0, 32'h0,        4'hF, 0, 1, 36'h900000099};

    for (int n = 0; n < 16; n++) begin
      nrst          = tbl[n].rst;
      rob_clear     = tbl[n].clr;
      req_valid     = tbl[n].v;
      req_exception = tbl[n].exc;
      for (int i = 0; i < N; i++) req_data[i] = {tbl[n].tag, tbl[n].dat};
      tick(r);
      chk($sformatf("vec%0d_ready", n), 64'(r), 64'(tbl[n].rdy));
      chk($sformatf("vec%0d_cdb_valid", n), 64'(cdb_valid), 64'(tbl[n].cv));
      chk($sformatf("vec%0d_cdb_exception", n), 64'(cdb_exception), 64'(tbl[n].cexc));
      chk($sformatf("vec%0d_cdb", n), 64'(cdb), 64'(tbl[n].ocdb));
    end
    rob_clear = 1'b0;

    // Full contention from reset: rotating one-hot ready and broadcast order 0,1,2,3,...
    nrst = 1'b1; set_req(4'h0, 4'h0); tick(r);
    nrst = 1'b0; set_req(4'hF, 4'hA);
    for (int c = 0; c < 13; c++) begin
      tick(r);
      if (c == 0) begin
        chk("contend_first_ready", 64'(r), 64'hF);
      end else begin
        chk($sformatf("contend%0d_ready", c), 64'(r), 64'(4'b0001 << ((c - 1) % 4)));
        chk($sformatf("contend%0d_valid", c), 64'(cdb_valid), 64'h1);
        chk($sformatf("contend%0d_unit", c), 64'(cdb[1:0]), 64'((c - 1) % 4));
      end
    end

    // Reset with three slots full and the pointer parked at 3.
    nrst = 1'b1; set_req(4'h0, 4'h0); tick(r);
    nrst = 1'b0; set_req(4'b1110, 4'h3); tick(r);
    set_req(4'b0000, 4'h0); tick(r);
    set_req(4'b0011, 4'h4); tick(r);
    nrst = 1'b1; set_req(4'hF, 4'h6); tick(r);
    chk("rst_mid_ready", 64'(r), 64'h0);
    chk("rst_mid_valid", 64'(cdb_valid), 64'h0);
    chk("rst_mid_cdb", 64'(cdb), 64'h0);
    chk("rst_mid_exc", 64'(cdb_exception), 64'h0);
    nrst = 1'b0; tick(r);
    chk("rst_rel_ready", 64'(r), 64'hF);
    chk("rst_rel_valid", 64'(cdb_valid), 64'h0);
    set_req(4'h0, 4'h0); tick(r);
    chk("rst_first_valid", 64'(cdb_valid), 64'h1);
    chk("rst_first_unit", 64'(cdb[1:0]), 64'h0);

    // Random traffic; a unit not accepted keeps its request stable.
    tick(r);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      nrst      = ($urandom_range(99) == 0);
      rob_clear = ($urandom_range(19) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !r[i])) begin
          req_valid[i]     = 1'($urandom_range(1));
          req_exception[i] = 1'($urandom_range(1));
          req_data[i]      = {4'($urandom), $urandom};
        end
      end
      tick(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) among the functional units that complete out of order. Each unit hands its result (reorder-buffer tag plus data) and an exception flag to a one-entry holding slot. A round-robin scheduler picks one occupied slot per cycle and drives it onto a registered `cdb`/`cdb_valid`/`cdb_exception`. That output feeds the reorder buffer and the reservation stations. A flush from the branch unit discards every pending result.

## Interface
- `N_REQ`, default 4: number of requesting functional units; must be ≥2.
- `CDB_W`, default `fcpu_pkg::CDB_W`: result width, laid out as `{rsv_id[RSV_ID_W-1:0], data[DATA_W-1:0]}`.
- `clk`, input, 1: clock.
- `nrst`, input, 1: reset, synchronous, active-high.
- `req_valid`, input, N_REQ: unit i presents a result.
- `req_ready`, output, N_REQ: slot i accepts this cycle.
- `req_data`, input, N_REQ×CDB_W: per-unit result.
- `req_exception`, input, N_REQ: per-unit exception flag.
- `rob_clear`, input, 1: flush from the branch unit.
- `cdb_valid`, output, 1: broadcast valid.
- `cdb_exception`, output, 1: broadcast exception flag.
- `cdb`, output, CDB_W: broadcast payload.

## Operation
- Per unit i: holding slot with `hold_valid[i]`, `hold_data[i]` and `hold_exc[i]`.
- Acceptance: `req_ready[i] = ~nrst & ~rob_clear & (~hold_valid[i] | grant[i])`.
  - On `req_valid[i] & req_ready[i]`, the slot loads the request.
  - A slot that is granted this cycle refills in the same cycle.
- Grant: one-hot over `hold_valid`.
  - Round-robin: the search starts at `rr_ptr` and wraps from N_REQ-1 to 0.
  - After granting slot k, `rr_ptr` becomes `(k+1) mod N_REQ`.
  - When no slot is occupied, `rr_ptr` holds its value.
- Output register:
  - `cdb_valid <= |hold_valid & ~rob_clear`.
  - `cdb <= hold_data[k]` and `cdb_exception <= hold_exc[k]`.
  - When nothing is granted, `cdb` and `cdb_exception` hold their previous value.
- Granted slot: cleared unless it refills in the same cycle.
- `rob_clear`:
  - Clears all `hold_valid` at the clock edge.
  - No grant is issued.
  - `cdb_valid` is 0 in the following cycle.
  - `rr_ptr` is unchanged.
  - A `cdb_valid` already registered before the flush cycle is still presented during the flush cycle; the ROB discards it.

## Timing
- Reset (`nrst=1`), next edge:
  - `hold_valid = 0`, `rr_ptr = 0`.
  - `cdb_valid = 0`, `cdb_exception = 0`, `cdb = 0`.
  - `req_ready = 0` while `nrst` is high.
- Reset applied mid-operation drops all pending results without broadcasting them.
- Latency: a request accepted at edge t is broadcast at edge t+1 at the earliest, i.e. visible on `cdb` one cycle after acceptance.
- Throughput: one broadcast per cycle.
- Each unit sustains one result per cycle while it wins every grant; under full contention each unit gets 1 of every N_REQ cycles.
- Holding: a unit with `req_ready=0` holds `req_valid`/`req_data` stable.
- Fairness bound: no occupied slot waits more than N_REQ-1 grants.

## Configuration
- `CDB_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest-index occupied slot always wins.
  - `rr_ptr` is removed.
  - Starvation of high indices is permitted.
- Undefined (default): round-robin exactly as above.

## Structure
- `fcpu_pkg` holds:
  - `CDB_W`, `DATA_W` and `RSV_ID_W` (existing).
  - New constant `N_CDB_REQ = 4`.
  - New typedef `cdb_req_t {logic exception; logic [CDB_W-1:0] data;}` for the slot contents.
- Sub-module `rr_arbiter`:
  - Parameter N.
  - Inputs `req[N]` and `ptr`; outputs `grant[N]` (one-hot) and `any`.
  - Purely combinational; the pointer register and the `CDB_ARB_FIXED_PRIO_EN` selection live in `cdb_arbiter`.

## Test plan
- Configuration for all scenarios: N_REQ=4, DATA_W=32, RSV_ID_W=4.
- Single request: unit 2 presents tag 5, data 0xDEADBEEF for one cycle → the next cycle `cdb_valid=1`, `cdb={4'h5,32'hDEADBEEF}`, `cdb_exception=0`; the cycle after, `cdb_valid=0`.
- Full contention: all four units hold `req_valid=1` continuously from reset, with `rr_ptr=0` → broadcast order of units is 0,1,2,3,0,1…; each `req_ready` is high exactly one cycle in four.
- Back-to-back: unit 1 alone issues tags 1,2,3 on consecutive cycles → `req_ready[1]` stays 1 and `cdb` carries tags 1,2,3 on three consecutive cycles.
- Flush: units 0 and 3 are occupied and `rob_clear` is pulsed → `req_ready=0` during the pulse, `cdb_valid=0` the next cycle, and neither result is ever broadcast.
- Exception: unit 3 presents `req_exception=1`, tag 9 → the broadcast cycle shows `cdb_exception=1`, `cdb[35:32]=9`.
- Reset mid-stream: `nrst` is asserted while three slots are full → after the edge, `cdb_valid=0`, `cdb=0`, `req_ready=0`; after release, the first grant goes to unit 0.
